// File: rtl/tcb_full_pkg.sv
// tcb_full_pkg: shared TCB-Full configuration and response types
package tcb_full_pkg;
  typedef struct packed {
    int unsigned dly;
    logic        hld;
  } tcb_hsk_t;
  typedef struct packed {
    int unsigned adr;
    int unsigned dat;
  } tcb_bus_t;
  typedef struct packed {
    int unsigned aln;
    logic        mis;
  } tcb_pma_t;
  typedef struct packed {
    tcb_hsk_t hsk;
    tcb_bus_t bus;
    tcb_pma_t pma;
  } tcb_cfg_t;
  typedef struct packed {
    logic err;
  } tcb_rsp_sts_t;
  localparam tcb_bus_t TCB_BUS_DEF = '{adr: 32, dat: 32};
  localparam tcb_pma_t TCB_PMA_DEF = '{aln: 2, mis: 1'b0};
endpackage

// File: rtl/tcb_full_lib_trn_tracker.sv
// tcb_full_lib_trn_tracker: fixed-latency delay line tagging transfers with side data
module tcb_full_lib_trn_tracker #(
  parameter int unsigned DLY = 1,
  parameter int unsigned W   = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         trn,
  input  logic [W-1:0] dat,
  output logic         ena,
  output logic [W-1:0] dat_o
);
  if (DLY == 0) begin : g_comb
    assign ena   = trn;
    assign dat_o = dat;
  end else begin : g_dly
    logic [DLY-1:0] ena_q, ena_d;
    logic [W-1:0]   dat_q [DLY];
    logic [W-1:0]   dat_d [DLY];
    // shift every cycle without stall; stage 0 is the live transfer
    always_comb begin
      ena_d[0] = trn;
      dat_d[0] = dat;
      for (int i = 1; i < DLY; i++) begin
        ena_d[i] = ena_q[i-1];
        dat_d[i] = dat_q[i-1];
      end
    end
    // reset discards any in-flight transfers
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        ena_q <= '0;
        for (int i = 0; i < DLY; i++) dat_q[i] <= '0;
      end else begin
        ena_q <= ena_d;
        dat_q <= dat_d;
      end
    end
    assign ena   = ena_q[DLY-1];
    assign dat_o = dat_q[DLY-1];
  end
endmodule

// File: rtl/tcb_full_lib_register_response.sv
// tcb_full_lib_register_response: registers the response path, request passes through
module tcb_full_lib_register_response
  import tcb_full_pkg::*;
#(
  parameter tcb_cfg_t CFG_MAN = '{hsk: '{dly: 0, hld: 1'b1}, bus: TCB_BUS_DEF, pma: TCB_PMA_DEF},
  parameter tcb_cfg_t CFG_SUB = '{hsk: '{dly: 1, hld: 1'b1}, bus: TCB_BUS_DEF, pma: TCB_PMA_DEF}
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               sub_vld,
  input  logic                               sub_wen,
  input  logic [CFG_SUB.bus.adr-1:0]         sub_adr,
  input  logic [CFG_SUB.bus.dat/8-1:0]       sub_byt,
  input  logic [CFG_SUB.bus.dat-1:0]         sub_wdt,
  output logic [CFG_SUB.bus.dat-1:0]         sub_rdt,
  output logic [$bits(tcb_rsp_sts_t)-1:0]    sub_sts,
  output logic                               sub_rdy,
  output logic                               man_vld,
  output logic                               man_wen,
  output logic [CFG_MAN.bus.adr-1:0]         man_adr,
  output logic [CFG_MAN.bus.dat/8-1:0]       man_byt,
  output logic [CFG_MAN.bus.dat-1:0]         man_wdt,
  input  logic [CFG_MAN.bus.dat-1:0]         man_rdt,
  input  logic [$bits(tcb_rsp_sts_t)-1:0]    man_sts,
  input  logic                               man_rdy
);
  localparam int unsigned DW = CFG_SUB.bus.dat;
  localparam int unsigned SW = $bits(tcb_rsp_sts_t);
  if (CFG_SUB.hsk.dly != CFG_MAN.hsk.dly + 1) begin : g_dly_chk
    $fatal(1, "sub handshake delay must be man delay plus one");
  end
  if (CFG_SUB.bus != CFG_MAN.bus || CFG_SUB.pma != CFG_MAN.pma) begin : g_bus_chk
    $fatal(1, "bus and pma configuration must match on both ports");
  end
  assign man_vld = sub_vld;
  assign man_wen = sub_wen;
  assign man_adr = sub_adr;
  assign man_byt = sub_byt;
  assign man_wdt = sub_wdt;
  assign sub_rdy = man_rdy;
  logic cap, cap_wen;
  tcb_full_lib_trn_tracker #(.DLY(CFG_MAN.hsk.dly), .W(1)) u_trk (
    .clk  (clk),
    .rst  (rst),
    .trn  (man_vld & man_rdy),
    .dat  (man_wen),
    .ena  (cap),
    .dat_o(cap_wen)
  );
  logic [DW-1:0] rdt_q, rdt_d;
  logic [SW-1:0] sts_q, sts_d;
  // load on capture only, so man_rsp is ignored at every other cycle; writes keep old rdt
  always_comb begin
    sts_d = cap ? man_sts : sts_q;
    rdt_d = (cap && !cap_wen) ? man_rdt : rdt_q;
  end
  // response register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdt_q <= '0;
      sts_q <= '0;
    end else begin
      rdt_q <= rdt_d;
      sts_q <= sts_d;
    end
  end
  assign sub_rdt = rdt_q;
  assign sub_sts = sts_q;
endmodule

// File: tb/tb_tcb_full_lib_register_response.sv
// tb_tcb_full_lib_register_response: directed checks of the registered response slice
module tb_tcb_full_lib_register_response;
  import tcb_full_pkg::*;
  localparam tcb_cfg_t CFG_MAN = '{hsk: '{dly: 1, hld: 1'b1}, bus: TCB_BUS_DEF, pma: TCB_PMA_DEF};
  localparam tcb_cfg_t CFG_SUB = '{hsk: '{dly: 2, hld: 1'b1}, bus: TCB_BUS_DEF, pma: TCB_PMA_DEF};
  logic        clk = 1'b0;
  logic        rst;
  logic        sub_vld, sub_wen, sub_rdy;
  logic [31:0] sub_adr, sub_wdt, sub_rdt;
  logic [3:0]  sub_byt;
  logic [0:0]  sub_sts;
  logic        man_vld, man_wen, man_rdy;
  logic [31:0] man_adr, man_wdt, man_rdt;
  logic [3:0]  man_byt;
  logic [0:0]  man_sts;
  int tests = 0;
  int fails = 0;
  always #5 clk = ~clk;
  tcb_full_lib_register_response #(.CFG_MAN(CFG_MAN), .CFG_SUB(CFG_SUB)) dut (
    .clk(clk), .rst(rst),
    .sub_vld(sub_vld), .sub_wen(sub_wen), .sub_adr(sub_adr), .sub_byt(sub_byt),
    .sub_wdt(sub_wdt), .sub_rdt(sub_rdt), .sub_sts(sub_sts), .sub_rdy(sub_rdy),
    .man_vld(man_vld), .man_wen(man_wen), .man_adr(man_adr), .man_byt(man_byt),
    .man_wdt(man_wdt), .man_rdt(man_rdt), .man_sts(man_sts), .man_rdy(man_rdy)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic req(input logic v, input logic w, input logic [31:0] a, input logic [31:0] d);
    sub_vld = v;
    sub_wen = w;
    sub_adr = a;
    sub_wdt = d;
    sub_byt = 4'hF;
  endtask
  task automatic rsp(input logic [31:0] r, input logic s);
    man_rdt = r;
    man_sts = s;
  endtask
  task automatic tick();
    @(negedge clk);
  endtask
  initial begin
    rst = 1'b0;
    man_rdy = 1'b1;
    req(1'b0, 1'b0, 32'h0, 32'h0);
    rsp(32'h0, 1'b0);
    tick();
    tick();
    chk("reset_rdt", sub_rdt, 32'h0);
    chk("reset_sts", {31'h0, sub_sts}, 32'h0);
    rst = 1'b1;
    // write
    req(1'b1, 1'b1, 32'h01234567, 32'h76543210);
    rsp(32'h5A5A5A5A, 1'b1);
    #1;
    chk("pass_adr", man_adr, 32'h01234567);
    chk("pass_wdt", man_wdt, 32'h76543210);
    chk("pass_vld_wen", {30'h0, man_vld, man_wen}, 32'h3);
    tick();
    req(1'b0, 1'b0, 32'h0, 32'h0);
    rsp(32'hBAD0BAD0, 1'b0);
    tick();
    chk("wr_sts", {31'h0, sub_sts}, 32'h0);
    chk("wr_rdt_kept", sub_rdt, 32'h0);
    // read
    req(1'b1, 1'b0, 32'h89ABCDEF, 32'h0);
    rsp(32'h55555555, 1'b1);
    tick();
    req(1'b0, 1'b0, 32'h0, 32'h0);
    rsp(32'hFEDCBA98, 1'b0);
    #1;
    chk("rd_not_early", sub_rdt, 32'h0);
    tick();
    chk("rd_rdt", sub_rdt, 32'hFEDCBA98);
    chk("rd_sts", {31'h0, sub_sts}, 32'h0);
    rsp(32'h13579BDF, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rd_hold", {sub_rdt[31:1], sub_rdt[0] ^ sub_sts[0]}, 32'hFEDCBA98);
    end
    // back-to-back reads
    req(1'b1, 1'b0, 32'h10, 32'h0);
    tick();
    req(1'b1, 1'b0, 32'h14, 32'h0);
    rsp(32'h11111111, 1'b0);
    tick();
    req(1'b1, 1'b0, 32'h18, 32'h0);
    rsp(32'h22222222, 1'b0);
    chk("b2b_0", sub_rdt, 32'h11111111);
    tick();
    req(1'b0, 1'b0, 32'h0, 32'h0);
    rsp(32'h33333333, 1'b0);
    chk("b2b_1", sub_rdt, 32'h22222222);
    tick();
    rsp(32'hEEEEEEEE, 1'b1);
    chk("b2b_2", sub_rdt, 32'h33333333);
    // read / write / read
    req(1'b1, 1'b0, 32'h20, 32'h0);
    tick();
    req(1'b1, 1'b1, 32'h24, 32'hCAFEF00D);
    rsp(32'hAAAA5555, 1'b0);
    tick();
    req(1'b1, 1'b0, 32'h28, 32'h0);
    rsp(32'hCCCCCCCC, 1'b1);
    chk("rwr_0_rdt", sub_rdt, 32'hAAAA5555);
    chk("rwr_0_sts", {31'h0, sub_sts}, 32'h0);
    tick();
    req(1'b0, 1'b0, 32'h0, 32'h0);
    rsp(32'h0F0F0F0F, 1'b0);
    chk("rwr_1_rdt", sub_rdt, 32'hAAAA5555);
    chk("rwr_1_sts", {31'h0, sub_sts}, 32'h1);
    tick();
    chk("rwr_2_rdt", sub_rdt, 32'h0F0F0F0F);
    chk("rwr_2_sts", {31'h0, sub_sts}, 32'h0);
    // backpressure
    man_rdy = 1'b0;
    req(1'b1, 1'b0, 32'h30, 32'h0);
    rsp(32'h99999999, 1'b1);
    #1;
    chk("bp_rdy", {31'h0, sub_rdy}, 32'h0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("bp_hold_rdt", sub_rdt, 32'h0F0F0F0F);
      chk("bp_hold_sts", {31'h0, sub_sts}, 32'h0);
    end
    man_rdy = 1'b1;
    tick();
    req(1'b0, 1'b0, 32'h0, 32'h0);
    rsp(32'h12345678, 1'b0);
    chk("bp_not_early", sub_rdt, 32'h0F0F0F0F);
    tick();
    rsp(32'h77777777, 1'b1);
    chk("bp_done", sub_rdt, 32'h12345678);
    // reset mid-flight
    req(1'b1, 1'b0, 32'h40, 32'h0);
    tick();
    req(1'b0, 1'b0, 32'h0, 32'h0);
    rsp(32'hDEADBEEF, 1'b1);
    rst = 1'b0;
    #1;
    chk("rst_async_rdt", sub_rdt, 32'h0);
    tick();
    rst = 1'b1;
    tick();
    tick();
    chk("rst_late_rdt", sub_rdt, 32'h0);
    chk("rst_late_sts", {31'h0, sub_sts}, 32'h0);
    // first transfer after reset release
    req(1'b1, 1'b0, 32'h44, 32'h0);
    rsp(32'h0, 1'b0);
    tick();
    req(1'b0, 1'b0, 32'h0, 32'h0);
    rsp(32'h600DF00D, 1'b0);
    tick();
    chk("post_rst_rd", sub_rdt, 32'h600DF00D);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/tcb_full_lib_register_response.md
# tcb_full_lib_register_response

Register slice for the TCB-Full response path. It places a flop stage on `rdt`/`sts` between a downstream subordinate and an upstream manager, so the subordinate's read-data timing is decoupled from the manager's capture logic. It pairs with `tcb_full_lib_register_request`, which covers the request path. The request path passes through combinationally, and the upstream-visible response delay is one cycle longer than the downstream delay.

## Interface
- `CFG_SUB` — default `sub.CFG`. Configuration of the upstream-facing port; `HSK.DLY` must equal `CFG_MAN.HSK.DLY+1`.
- `CFG_MAN` — default `man.CFG`. Configuration of the downstream-facing port; `BUS` and `PMA` must be identical to `CFG_SUB`.
- `clk  input  1` — clock, rising edge.
- `rst  input  1` — reset, asynchronous, active-low (`rst==0` resets).
- `sub  tcb_full_if.sub  —` — upstream port; the upstream manager connects here.
- `man  tcb_full_if.man  —` — downstream port; connects to the downstream subordinate.

## Operation
- Handshake is `trn = vld & rdy` on each port.
- A response appears exactly `HSK.DLY` cycles after the matching `trn`. Responses are never reordered or dropped.
- **Request path (combinational):**
  - `man.vld = sub.vld`
  - `man.req = sub.req`
  - `sub.rdy = man.rdy`
- **Tracker:** shift register `trk[0:CFG_MAN.HSK.DLY]` of `{ena, wen}`.
  - `trk[0] = {man.trn, man.req.wen}` (combinational).
  - Stages 1.. are flopped and shift every cycle, with no stall.
- **Capture point:** the cycle where `trk[CFG_MAN.HSK.DLY].ena==1`.
  - When `CFG_MAN.HSK.DLY==0`, the capture point is the `trn` cycle itself.
- **Response register `rsp_q`:**
  - At the capture point, `sts` always loads from `man.rsp.sts`.
  - `rdt` loads from `man.rsp.rdt` only if the tracked `wen==0` (read). On writes, `rdt` keeps its previous value.
  - Outside capture points, `rsp_q` holds, which satisfies `HLD=1` semantics for both `HLD` settings.
- **Outputs:** `sub.rsp = rsp_q` (registered). No combinational path exists from `man.rsp` to `sub.rsp`.
- **Elaboration checks:** `$fatal` on a `DLY` mismatch or on a `BUS`/`PMA` mismatch.

## Timing
- **Reset:**
  - `trk` stages 1.. clear to 0.
  - `rsp_q.rdt` resets to all zeros; `rsp_q.sts` resets to `'0`.
  - Request-path outputs follow their inputs; there is no reset state on them.
- **Latency:** response visible on `sub` at `trn + CFG_MAN.HSK.DLY + 1` = `trn + CFG_SUB.HSK.DLY`.
- **Throughput:** one transfer per cycle. Back-to-back transfers capture on consecutive cycles with no bubble.
- **Mixed sequences:** in a read/write/read sequence, the write's cycle shows the first read's `rdt` and the write's `sts`.
- **Reset mid-operation:** in-flight tracker entries are discarded. Responses arriving from `man` after reset release, for pre-reset transfers, are not captured.
- **Reset release:** asynchronous assertion, synchronous deassertion at the block boundary (the synchronizer is external). The first `trn` is allowed on the first rising edge with `rst==1`.
- **`sub.vld` with `man.rdy==0`:** no `trn`, nothing tracked, `rsp_q` unchanged.
- **`X` on `man.rsp` outside capture points:** never propagates to `sub.rsp`.

## Structure
- **`tcb_full_pkg`:** holds `tcb_cfg_t`, `tcb_rsp_sts_t`, and the `TCB_BUS_DEF`/`TCB_PMA_DEF` constants. No new package types are added.
- **Sub-module `tcb_full_lib_trn_tracker`:**
  - Parameters `DLY` and `W`.
  - Inputs `clk`, `rst`, `trn`, `dat[W]`.
  - Outputs `ena`, `dat_o[W]`.
  - It is a generic delay line, reused later by other fixed-latency adapters.
- **Top level:** tracker instance, `rsp_q` flops, pass-through assigns and elaboration checks. Target size is about 150 lines.

## Test plan
The bench uses `CFG_MAN.DLY=1`, `CFG_SUB.DLY=2` and `HLD=1`, with protocol checkers on both ports.
- **Write:** write `adr=32'h01234567`, `wdt=32'h76543210`, sub returns `sts=0` → `sub.rsp.sts==0` two cycles after `sub.trn`; `rdt` keeps its reset value `32'h0`.
- **Read:** read `adr=32'h89ABCDEF`, sub returns `rdt=32'hFEDCBA98` → `sub.rsp.rdt==32'hFEDCBA98` exactly at `trn+2`. `rdt` stays held across 3 idle cycles.
- **Back-to-back reads:** reads to `0x10`, `0x14`, `0x18` returning `32'h11111111`, `32'h22222222`, `32'h33333333` → the same values appear on consecutive cycles at `trn+2`, in order.
- **Read/write/read:** read `32'hAAAA5555`, write with `sts=1` (error), read `32'h0F0F0F0F` → `sub` sees `(rdt,sts)` = `(AAAA5555,0)`, `(AAAA5555,1)`, `(0F0F0F0F,0)` on successive cycles.
- **Backpressure:** hold `man.rdy=0` for 4 cycles with `sub.vld=1` → no capture and `rsp_q` unchanged. The transfer completes on the first `rdy` cycle, with its response at `+2`.
- **Reset mid-flight:** assert `rst=0` one cycle after a read `trn` → `rsp_q` clears immediately (asynchronously). The late `man.rsp.rdt=32'hDEADBEEF` is not captured; `sub.rsp.rdt==0` after release.
